// File: rtl/sensor_adc_sampler.sv
// Periodic 16-bit serial read of the optical-sensor ADC, triggered every DECIM sensor_clk ticks,
// result presented on a valid/ready port. Optional frame averaging with `define SENSOR_AVG_EN.
module sensor_adc_sampler #(
  parameter int DATA_W     = 12,
  parameter int FRAME_BITS = 16,
  parameter int DECIM      = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic              clk_3M,
  input  logic              reset,
  input  logic              sensor_clk,
  input  logic              enable,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_sdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic [1:0]        state_dbg
);

  // Handshake: the consumer takes sample on any clk_3M edge where sample_valid && sample_ready;
  // sample is held while valid && !ready, except that a newly completed result replaces it.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_QUIET = 2'd3;

  localparam int TICK_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CNT_W  = $clog2(2 * FRAME_BITS);
  // An illegal parameter set never starts a frame.
  localparam bit CFG_OK = (DECIM >= 1) && (DATA_W <= FRAME_BITS) && (AVG_LOG2 >= 0);

  logic [TICK_W-1:0]     tick_cnt;
  logic                  trigger;
  logic [1:0]            state;
  logic [CNT_W-1:0]      phase_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  frame_done;
  logic [DATA_W-1:0]     frame_data;
  logic                  result_load;
  logic [DATA_W-1:0]     result_data;
  logic                  ovr_set;

  // ---------------------------------------------------------------- tick decimator
  assign trigger = CFG_OK && enable && sensor_clk &&
                   (tick_cnt == TICK_W'(DECIM - 1));

  always_ff @(posedge clk_3M or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!enable) begin
      tick_cnt <= '0;
    end else if (sensor_clk) begin
      if (tick_cnt == TICK_W'(DECIM - 1)) tick_cnt <= '0;
      else                                tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- serial frame FSM
  assign frame_done = (state == ST_SHIFT) &&
                      (phase_cnt == CNT_W'(2 * FRAME_BITS - 1));
  assign frame_data = shift_reg[DATA_W-1:0];

  always_ff @(posedge clk_3M or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      shift_reg <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state     <= ST_SETUP;
            adc_cs_n  <= 1'b0;
            adc_sclk  <= 1'b1;
            shift_reg <= '0;
          end
        end
        ST_SETUP: begin
          state     <= ST_SHIFT;
          adc_sclk  <= 1'b0;
          phase_cnt <= '0;
        end
        ST_SHIFT: begin
          if (frame_done) begin
            state    <= ST_QUIET;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
            adc_sclk  <= ~adc_sclk;
            // ADC data changed on the preceding SCLK fall; capture as SCLK rises.
            if (!adc_sclk) shift_reg <= {shift_reg[FRAME_BITS-2:0], adc_sdata};
          end
        end
        ST_QUIET: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // ---------------------------------------------------------------- result path
`ifdef SENSOR_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int FRM_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [FRM_W-1:0] frm_cnt;
  logic             frm_last;

  assign acc_sum     = acc + ACC_W'(frame_data);
  assign frm_last    = (frm_cnt == FRM_W'((1 << AVG_LOG2) - 1));
  assign result_load = frame_done && frm_last;
  assign result_data = DATA_W'(acc_sum >> AVG_LOG2);

  always_ff @(posedge clk_3M or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      frm_cnt <= '0;
    end else if (frame_done) begin
      if (frm_last) begin
        acc     <= '0;
        frm_cnt <= '0;
      end else begin
        acc     <= acc_sum;
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end
`else
  assign result_load = frame_done;
  assign result_data = frame_data;
`endif

  // A result landing on an unaccepted one, or a trigger while a frame is in flight, is an overrun.
  assign ovr_set = (trigger && (state != ST_IDLE)) ||
                   (result_load && sample_valid && !sample_ready);

  always_ff @(posedge clk_3M or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (result_load) begin
        sample       <= result_data;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_adc_sampler.sv
// Directed bench for sensor_adc_sampler: frame timing, handshake, overrun, enable, reset abort.
// Build with +define+SENSOR_AVG_EN to run the averaging scenario instead.
`timescale 1ns/1ps
module tb_sensor_adc_sampler;

  // ---------------------------------------------------------------- clock / reset
  logic clk_3M = 1'b0;
  logic reset;
  always #5 clk_3M = ~clk_3M;

  // main instance (DECIM=4) signals
  logic        sensor_clk, enable, adc_sdata, sample_ready, overrun_clr;
  logic        adc_cs_n, adc_sclk, sample_valid, busy, overrun;
  logic [11:0] sample;
  logic [1:0]  state_dbg;

  // second instance (DECIM=1) signals
  logic        sensor_clk1, enable1, sample_ready1;
  logic        adc_cs_n1, adc_sclk1, sample_valid1, busy1, overrun1;
  logic [11:0] sample1;
  logic [1:0]  state_dbg1;

  sensor_adc_sampler #(.DATA_W(12), .FRAME_BITS(16), .DECIM(4), .AVG_LOG2(2)) dut (
    .clk_3M(clk_3M), .reset(reset), .sensor_clk(sensor_clk), .enable(enable),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sdata(adc_sdata),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr), .state_dbg(state_dbg)
  );

  sensor_adc_sampler #(.DATA_W(12), .FRAME_BITS(16), .DECIM(1), .AVG_LOG2(2)) dut1 (
    .clk_3M(clk_3M), .reset(reset), .sensor_clk(sensor_clk1), .enable(enable1),
    .adc_cs_n(adc_cs_n1), .adc_sclk(adc_sclk1), .adc_sdata(1'b1),
    .sample(sample1), .sample_valid(sample_valid1), .sample_ready(sample_ready1),
    .busy(busy1), .overrun(overrun1), .overrun_clr(1'b0), .state_dbg(state_dbg1)
  );

  // ---------------------------------------------------------------- ADC model
  logic [15:0] adc_word;
  int          adc_idx;
  int          rise_cnt;
  int          falls1;

  always @(negedge adc_cs_n) begin
    adc_idx  = 15;
    rise_cnt = 0;
  end
  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0 && adc_idx >= 0) begin
      adc_sdata = adc_word[adc_idx];
      adc_idx--;
    end
  end
  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) rise_cnt++;
  always @(negedge adc_cs_n1) falls1++;

  // ---------------------------------------------------------------- scoreboard
  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic cyc();
    @(posedge clk_3M);
    #1;
  endtask

  // one sensor_clk tick after 'gap' idle cycles; returns 1ns after the tick edge
  task automatic tick_after(input int gap);
    repeat (gap) cyc();
    sensor_clk = 1'b1;
    cyc();
    sensor_clk = 1'b0;
  endtask

  // four ticks 20 cycles apart; returns 1ns after the triggering edge T
  task automatic trigger_frame();
    for (int k = 0; k < 4; k++) tick_after(19);
  endtask

  task automatic tick1();
    sensor_clk1 = 1'b1;
    cyc();
    sensor_clk1 = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    adc_word = w;
    exp_q.push_back(w[11:0]);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int bcnt, vcnt, bad;
    logic [11:0] vsample;
    logic [11:0] e;
    reset = 1'b1;
    sensor_clk = 0; enable = 0; adc_sdata = 0; sample_ready = 0; overrun_clr = 0;
    sensor_clk1 = 0; enable1 = 0; sample_ready1 = 1;
    adc_word = 16'h0000; adc_idx = 15; rise_cnt = 0; falls1 = 0;
    #1;
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state", state_dbg, 0);
    repeat (3) cyc();
    reset = 1'b0;
    enable = 1'b1;
    cyc();

`ifdef SENSOR_AVG_EN
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adc_word = 16'(100 + i);
      trigger_frame();
      repeat (33) cyc();
      if (i < 3) chk("avg_no_valid", sample_valid, 0);
    end
    chk("avg_valid", sample_valid, 1);
    chk("avg_sample", sample, 12'd101);
    cyc();
    chk("avg_pulse", sample_valid, 0);
`else
    // 1: basic frame, latency and SCLK count
    load_word(16'h0ABC);
    trigger_frame();
    chk("t1_cs_fall", adc_cs_n, 0);
    chk("t1_busy", busy, 1);
    chk("t1_setup", state_dbg, 1);
    repeat (32) cyc();
    chk("t1_cs_low_T32", adc_cs_n, 0);
    chk("t1_novalid_T32", sample_valid, 0);
    cyc();
    e = exp_q.pop_front();
    chk("t1_cs_rise_T33", adc_cs_n, 1);
    chk("t1_valid_T33", sample_valid, 1);
    chk("t1_sample", sample, e);
    chk("t1_rises", rise_cnt, 16);
    chk("t1_quiet", state_dbg, 3);
    cyc();
    chk("t1_idle_T34", state_dbg, 0);
    chk("t1_valid_hold", sample_valid, 1);
    sample_ready = 1'b1;
    cyc();
    chk("t1_valid_clr", sample_valid, 0);

    // 2: ready high -> one-cycle valid pulse, busy 34 cycles
    load_word(16'h0357);
    trigger_frame();
    bcnt = 0; vcnt = 0; vsample = '0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) bcnt++;
      if (sample_valid === 1'b1) begin vcnt++; vsample = sample; end
      cyc();
    end
    e = exp_q.pop_front();
    chk("t2_busy_len", bcnt, 34);
    chk("t2_valid_len", vcnt, 1);
    chk("t2_sample", vsample, e);
    chk("t2_no_overrun", overrun, 0);

    // 3: unaccepted result overwritten -> overrun; clear; set beats clear
    sample_ready = 1'b0;
    load_word(16'h0123);
    trigger_frame();
    repeat (33) cyc();
    e = exp_q.pop_front();
    chk("t3_first", sample, e);
    chk("t3_first_ovr", overrun, 0);
    load_word(16'h0456);
    trigger_frame();
    repeat (33) cyc();
    e = exp_q.pop_front();
    chk("t3_overwrite", sample, e);
    chk("t3_valid", sample_valid, 1);
    chk("t3_overrun", overrun, 1);
    overrun_clr = 1'b1;
    cyc();
    chk("t3_clr", overrun, 0);
    load_word(16'h0789);
    trigger_frame();
    repeat (33) cyc();
    e = exp_q.pop_front();
    chk("t3_set_wins", overrun, 1);
    chk("t3_third", sample, e);
    overrun_clr = 1'b0;
    sample_ready = 1'b1;
    cyc();
    chk("t3_drain", sample_valid, 0);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;

    // 4: DECIM=1 instance, tick every 20 cycles -> every other tick ignored
    enable1 = 1'b1;
    tick1();
    chk("t4_cs_fall", adc_cs_n1, 0);
    repeat (19) cyc();
    tick1();
    chk("t4_overrun", overrun1, 1);
    chk("t4_still_shift", state_dbg1, 2);
    repeat (13) cyc();
    chk("t4_valid", sample_valid1, 1);
    chk("t4_sample", sample1, 12'hFFF);
    repeat (6) cyc();
    tick1();
    chk("t4_restart", state_dbg1, 1);
    chk("t4_frames", falls1, 2);
    enable1 = 1'b0;
    repeat (40) cyc();

    // 5: enable low holds everything idle
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      sensor_clk = (i % 20 == 19);
      cyc();
      if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1 || sample_valid !== 1'b0) bad++;
    end
    sensor_clk = 1'b0;
    chk("t5_disabled_idle", bad, 0);
    enable = 1'b1;

    // 5b: reset during SHIFT aborts immediately
    adc_word = 16'h0ABC;
    trigger_frame();
    repeat (15) cyc();
    chk("t5_mid_shift", state_dbg, 2);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_cs_n", adc_cs_n, 1);
    chk("t5_rst_sclk", adc_sclk, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_sample", sample, 0);
    #2 reset = 1'b0;
    cyc();
    load_word(16'h05A3);
    trigger_frame();
    chk("t5_next_cs", adc_cs_n, 0);
    repeat (33) cyc();
    e = exp_q.pop_front();
    chk("t5_next_sample", sample, e);
    chk("t5_next_valid", sample_valid, 1);
    chk("t5_next_rises", rise_cnt, 16);
    chk("t5_sb_empty", exp_q.size(), 0);
`endif

    repeat (5) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
